// File: rtl/viterbi_pkg.sv
// Shared constants and types for the convolutional encoder and the Viterbi decoder.
// Keeping the generator taps here means the encoder and the branch-metric units use
// identical polynomials.
package viterbi_pkg;

  localparam int unsigned K_DEF = 3;
  // Bit K-1 taps the input bit, bit 0 taps the oldest state bit.
  localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
  localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_DATA,
    ENC_TAIL
  } enc_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step: given an input bit and the current shift-register
// state, produce the rate-1/2 code symbol and the next state.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter int unsigned     K  = K_DEF,
  parameter logic [K-1:0]    G0 = G0_DEF,
  parameter logic [K-1:0]    G1 = G1_DEF
) (
  input  logic         bit_i,
  input  logic [K-2:0] state_i,
  output sym_t         sym_o,
  output logic [K-2:0] state_o
);

  logic [K-1:0] v;

  // Parity of the tapped register vector; the new bit enters at the top.
  always_comb begin
    v       = {bit_i, state_i};
    sym_o   = {^(v & G0), ^(v & G1)};
    state_o = v[K-1:1];
  end

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 convolutional encoder with a valid/ready stream on both sides.
// One registered output stage; frames are optionally flushed with K-1 zero tail bits
// so the decoder's traceback always terminates in state 0.
module conv_encoder_k3
  import viterbi_pkg::*;
#(
  parameter int unsigned  K       = K_DEF,
  parameter logic [K-1:0] G0      = G0_DEF,
  parameter logic [K-1:0] G1      = G1_DEF,
  parameter bit           TAIL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  logic in_bit_i,
  input  logic in_last_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output sym_t out_sym_o,
  output logic out_last_o
);

  localparam int unsigned CntW = (K > 2) ? $clog2(K) : 1;

  enc_state_e     state_q, state_d;
  logic [K-2:0]   s_q;
  logic [CntW-1:0] cnt_q;
  logic           valid_q, last_q;
  sym_t           sym_q;

  logic           out_free, accept, tail_fire, last_tail, enc_bit, data_last_nt;
  sym_t           enc_sym;
  logic [K-2:0]   enc_state;

  assign out_free  = !valid_q || out_ready_i;
  assign accept    = in_valid_i && in_ready_o;
  assign tail_fire = (state_q == ENC_TAIL) && out_free;
  assign last_tail = tail_fire && (cnt_q == CntW'(1));
  // Last data bit of a frame when no tail is appended: that symbol ends the frame.
  assign data_last_nt = accept && in_last_i && !TAIL_EN;
  // Tail symbols shift in zeros.
  assign enc_bit   = (state_q == ENC_TAIL) ? 1'b0 : in_bit_i;

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .bit_i   (enc_bit),
    .state_i (s_q),
    .sym_o   (enc_sym),
    .state_o (enc_state)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: data phase until the last bit, then optional tail phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ENC_IDLE, ENC_DATA: begin
        if (accept) begin
          if (in_last_i) begin
            state_d = TAIL_EN ? ENC_TAIL : ENC_IDLE;
          end else begin
            state_d = ENC_DATA;
          end
        end
      end
      ENC_TAIL: begin
        if (last_tail) begin
          state_d = ENC_IDLE;
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  // FSM outputs: input is blocked while the tail is being flushed.
  always_comb begin
    in_ready_o = (state_q != ENC_TAIL) && out_free;
  end

  // Shift register and tail counter advance only on an accepted bit or a launched tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      s_q <= data_last_nt ? '0 : enc_state;
      if (in_last_i && TAIL_EN) begin
        cnt_q <= CntW'(K - 1);
      end
    end else if (tail_fire) begin
      s_q   <= enc_state;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Output register: loads on every new symbol, holds while stalled, drains on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sym_q   <= '0;
      last_q  <= 1'b0;
    end else if (accept || tail_fire) begin
      valid_q <= 1'b1;
      sym_q   <= enc_sym;
      last_q  <= data_last_nt || last_tail;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_sym_o   = sym_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Self-checking bench for conv_encoder_k3: a cycle table for the basic frame and the
// no-tail variant, directed multi-cycle sequences, and a random run scored against a
// frame-level polynomial model.
module tb_conv_encoder_k3;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with tail termination
  logic in_valid, in_ready, in_bit, in_last, out_valid, out_ready, out_last;
  sym_t out_sym;
  // DUT without tail
  logic nt_in_valid, nt_in_ready, nt_in_bit, nt_in_last, nt_out_valid, nt_out_ready;
  logic nt_out_last;
  sym_t nt_out_sym;

  conv_encoder_k3 #(.TAIL_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_bit_i    (in_bit),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sym_o   (out_sym),
    .out_last_o  (out_last)
  );

  conv_encoder_k3 #(.TAIL_EN(1'b0)) dut_nt (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (nt_in_valid),
    .in_ready_o  (nt_in_ready),
    .in_bit_i    (nt_in_bit),
    .in_last_i   (nt_in_last),
    .out_valid_o (nt_out_valid),
    .out_ready_i (nt_out_ready),
    .out_sym_o   (nt_out_sym),
    .out_last_o  (nt_out_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    bit       sel;   // 0 = tailed DUT, 1 = no-tail DUT
    bit       v, b, l;
    bit       ir, ov;
    bit [1:0] sym;
    bit       ol;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit sel, bit v, bit b, bit l, bit ir, bit ov, bit [1:0] sym,
                              bit ol);
    vec_t r;
    r.sel = sel; r.v = v; r.b = b; r.l = l; r.ir = ir; r.ov = ov; r.sym = sym; r.ol = ol;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  bit [1:0] in_q[$];    // {bit, last}
  bit [2:0] exp_q[$];   // {sym, last}
  bit       prev_stall;
  bit [2:0] prev_out;

  function automatic void push_frame(input bit bits[$]);
    for (int i = 0; i < bits.size(); i++) in_q.push_back({bits[i], i == bits.size() - 1});
  endfunction

  // Frame-level reference: convolve the bit sequence (plus K-1 zeros) with each generator.
  function automatic void model_frame(input bit bits[$]);
    int n     = bits.size();
    int total = n + int'(K_DEF) - 1;
    logic [K_DEF-1:0] g0 = G0_DEF;
    logic [K_DEF-1:0] g1 = G1_DEF;
    for (int i = 0; i < total; i++) begin
      bit p1 = 1'b0, p0 = 1'b0;
      for (int j = 0; j < int'(K_DEF); j++) begin
        bit u = (i - j >= 0 && i - j < n) ? bits[i - j] : 1'b0;
        p1 ^= g0[int'(K_DEF) - 1 - j] & u;
        p0 ^= g1[int'(K_DEF) - 1 - j] & u;
      end
      exp_q.push_back({p1, p0, i == total - 1});
    end
  endfunction

  // mode 0: ready always high; 1: fixed 1,0,0,1,0,1 pattern; 2: random valid/ready
  task automatic run(input int mode, input int budget, output int cycles);
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int cyc = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      in_valid = (in_q.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
      {in_bit, in_last} = (in_q.size() > 0) ? in_q[0] : 2'b00;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 6];
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (prev_stall) chk("stall_hold", {out_valid, out_sym, out_last}, {1'b1, prev_out});
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_symbol", {out_sym, out_last}, 32'hdead);
        else chk("symbol", {out_sym, out_last}, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_sym, out_last};
      cyc++;
    end
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      chk("run_timeout", in_q.size() + exp_q.size(), 0);
      in_q.delete();
      exp_q.delete();
    end
    // One idle cycle: nothing may follow the final symbol.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("no_trailing_symbol", out_valid, 1'b0);
    prev_stall = 1'b0;
    cycles = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 0; in_bit = 0; in_last = 0; out_ready = 1;
    nt_in_valid = 0; nt_in_bit = 0; nt_in_last = 0; nt_out_ready = 1;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles;
    bit fr[$];

    rst_n = 1'b1;
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_sym",   out_sym,   2'b00);
    chk("reset_out_last",  out_last,  1'b0);
    chk("reset_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame 1,0,1,1 with tail, then the no-tail DUT: frame {1,1} then {1}.
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 2'b00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 2'b11, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1, 2'b10, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1, 2'b00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2'b01, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2'b01, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2'b11, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 2'b00, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 2'b11, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 2'b01, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 2'b11, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2'b00, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      out_ready = 1'b1; nt_out_ready = 1'b1;
      in_valid    = tbl[i].sel ? 1'b0 : tbl[i].v;
      in_bit      = tbl[i].b;
      in_last     = tbl[i].l;
      nt_in_valid = tbl[i].sel ? tbl[i].v : 1'b0;
      nt_in_bit   = tbl[i].b;
      nt_in_last  = tbl[i].l;
      #1;
      if (!tbl[i].sel) begin
        chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
        chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
        if (tbl[i].ov) chk($sformatf("tbl%0d_sym_last", i), {out_sym, out_last},
                           {tbl[i].sym, tbl[i].ol});
      end else begin
        chk($sformatf("tbl%0d_nt_in_ready", i), nt_in_ready, tbl[i].ir);
        chk($sformatf("tbl%0d_nt_out_valid", i), nt_out_valid, tbl[i].ov);
        if (tbl[i].ov) chk($sformatf("tbl%0d_nt_sym_last", i), {nt_out_sym, nt_out_last},
                           {tbl[i].sym, tbl[i].ol});
      end
    end
    nt_in_valid = 1'b0;

    // Backpressure on the basic frame.
    fr = '{1'b1, 1'b0, 1'b1, 1'b1};
    push_frame(fr);
    exp_q = '{3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111};
    run(1, 200, cycles);

    // Back-to-back frames A={1}, B={1,1} at full rate.
    fr = '{1'b1};
    push_frame(fr);
    fr = '{1'b1, 1'b1};
    push_frame(fr);
    exp_q = '{3'b110, 3'b100, 3'b111, 3'b110, 3'b010, 3'b010, 3'b111};
    run(0, 100, cycles);
    chk("b2b_cycles", cycles, 8);

    // Reset while flushing the tail.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_bit    = 1'b1;
      in_last   = (i == 3);
      #1;
      chk("rst_frame_accept", in_ready, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_in_tail_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_out_last",  out_last,  1'b0);
    chk("rst_mid_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    fr = '{1'b1};
    push_frame(fr);
    exp_q = '{3'b110, 3'b100, 3'b111};
    run(0, 100, cycles);

    // Random frames against the polynomial model.
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 12);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(1'($urandom_range(0, 1)));
      push_frame(fr);
      model_frame(fr);
    end
    run(2, 8000, cycles);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
